// File: rtl/mem_arb_pkg.sv
// Shared encodings and the round-robin pick for the IF/MEM unified-RAM arbiter.
package mem_arb_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_MEM  = 2'd2;

  // On a tie, favour whichever stage did not win last time so neither starves.
  function automatic logic [1:0] pickOwner(input logic       ifReq,
                                           input logic       memReq,
                                           input logic [1:0] lastGrant);
    if (ifReq && memReq) return (lastGrant == OWN_IF) ? OWN_MEM : OWN_IF;
    if (memReq)          return OWN_MEM;
    if (ifReq)           return OWN_IF;
    return OWN_NONE;
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with enable, used for per-stage stall statistics.
module arb_sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {W{1'b1}})) count_d = count_q + W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port RAM between instruction fetch and load/store with wait states.
// Optional stall counters are built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic              mem_byte,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              ram_byte,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]       if_wait_cnt,
  output logic [15:0]       mem_wait_cnt
`endif
);

  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_STATES);

  logic [1:0]        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        lastGrant_q, lastGrant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              kill_q, kill_d;
  logic              ramCs_q, ramCs_d;
  logic              ramWe_q, ramWe_d;
  logic              ramByte_q, ramByte_d;
  logic [ADDR_W-1:0] ramAddr_q, ramAddr_d;
  logic [DATA_W-1:0] ramWdata_q, ramWdata_d;
  logic [DATA_W-1:0] ifRdata_q, ifRdata_d;
  logic [DATA_W-1:0] memRdata_q, memRdata_d;
  logic [1:0]        grant;

  assign grant = pickOwner(if_req, mem_req, lastGrant_q);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lastGrant_d = lastGrant_q;
    cnt_d       = cnt_q;
    kill_d      = kill_q;
    ramCs_d     = ramCs_q;
    ramWe_d     = ramWe_q;
    ramByte_d   = ramByte_q;
    ramAddr_d   = ramAddr_q;
    ramWdata_d  = ramWdata_q;
    ifRdata_d   = ifRdata_q;
    memRdata_d  = memRdata_q;
    case (state_q)
      ST_IDLE: begin
        kill_d = 1'b0;
        if (grant != OWN_NONE) begin
          owner_d     = grant;
          lastGrant_d = grant;
          cnt_d       = WAIT_CNT;
          ramCs_d     = 1'b1;
          state_d     = ST_ACCESS;
          if (grant == OWN_MEM) begin
            ramWe_d    = mem_we;
            ramByte_d  = mem_byte;
            ramAddr_d  = mem_addr;
            ramWdata_d = mem_wdata;
          end else begin
            ramWe_d   = 1'b0;
            ramByte_d = 1'b0;
            ramAddr_d = if_addr;
          end
        end
      end
      // A redirect only marks the fetch as dead; the RAM cycle still runs to completion.
      ST_ACCESS: begin
        if ((owner_q == OWN_IF) && if_cancel) kill_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          ramCs_d = 1'b0;
          state_d = ST_RESP;
          if (owner_q == OWN_IF)  ifRdata_d  = ram_rdata;
          else if (!ramWe_q)      memRdata_d = ram_rdata;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
        kill_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
        kill_d  = 1'b0;
        ramCs_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      lastGrant_q <= OWN_IF;
      cnt_q       <= '0;
      kill_q      <= 1'b0;
      ramCs_q     <= 1'b0;
      ramWe_q     <= 1'b0;
      ramByte_q   <= 1'b0;
      ramAddr_q   <= '0;
      ramWdata_q  <= '0;
      ifRdata_q   <= '0;
      memRdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lastGrant_q <= lastGrant_d;
      cnt_q       <= cnt_d;
      kill_q      <= kill_d;
      ramCs_q     <= ramCs_d;
      ramWe_q     <= ramWe_d;
      ramByte_q   <= ramByte_d;
      ramAddr_q   <= ramAddr_d;
      ramWdata_q  <= ramWdata_d;
      ifRdata_q   <= ifRdata_d;
      memRdata_q  <= memRdata_d;
    end
  end

  assign if_ready  = (state_q == ST_RESP) && (owner_q == OWN_IF) && !kill_q && !if_cancel;
  assign mem_ready = (state_q == ST_RESP) && (owner_q == OWN_MEM);
  assign if_rdata  = ifRdata_q;
  assign mem_rdata = memRdata_q;
  assign ram_cs    = ramCs_q;
  assign ram_we    = ramWe_q;
  assign ram_byte  = ramByte_q;
  assign ram_addr  = ramAddr_q;
  assign ram_wdata = ramWdata_q;

`ifdef ARB_PERF_CNT_EN
  arb_sat_counter #(.W(16)) u_ifWaitCnt (
    .clock   (clock),
    .reset   (reset),
    .en_i    (if_req & ~if_ready),
    .count_o (if_wait_cnt)
  );

  arb_sat_counter #(.W(16)) u_memWaitCnt (
    .clock   (clock),
    .reset   (reset),
    .en_i    (mem_req & ~mem_ready),
    .count_o (mem_wait_cnt)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (WAIT_STATES=1).
// Stall-counter checks are included when ARB_PERF_CNT_EN is defined.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, if_cancel, mem_req, mem_we, mem_byte;
  logic [15:0] if_addr, mem_addr, mem_wdata, ramRdata;
  logic [15:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic        if_ready, mem_ready, ram_cs, ram_we, ram_byte;
`ifdef ARB_PERF_CNT_EN
  logic [15:0] if_wait_cnt, mem_wait_cnt;
`endif

  int vectorCount = 0;
  int missCount   = 0;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(1)) dut (
    .clock     (clock),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_cancel (if_cancel),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_byte  (mem_byte),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_byte  (ram_byte),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ramRdata)
`ifdef ARB_PERF_CNT_EN
    ,
    .if_wait_cnt  (if_wait_cnt),
    .mem_wait_cnt (mem_wait_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Guard against a hung run; report and stop hard.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ifReq, input logic [15:0] ifAddr, input logic memReq,
                               input logic memWe, input logic memByte, input logic [15:0] memAddr,
                               input logic [15:0] memWdata);
    if_req    = ifReq;
    if_addr   = ifAddr;
    mem_req   = memReq;
    mem_we    = memWe;
    mem_byte  = memByte;
    mem_addr  = memAddr;
    mem_wdata = memWdata;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #2;
  endtask

  // Leaves the bench 2 time units into the first cycle after reset release.
  task automatic doReset();
    reset     = 1'b0;
    if_cancel = 1'b0;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    int ifPulses, memPulses, ifAt, memAt;
    bit ifSeen;
    ramRdata  = 16'h0;
    reset     = 1'b0;
    if_cancel = 1'b0;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    checkOutput("rst_ram_cs",    ram_cs,    0);
    checkOutput("rst_if_ready",  if_ready,  0);
    checkOutput("rst_mem_ready", mem_ready, 0);
    checkOutput("rst_if_rdata",  if_rdata,  0);
    checkOutput("rst_mem_rdata", mem_rdata, 0);
    checkOutput("rst_ram_addr",  ram_addr,  0);

    // Single fetch: select in cycles 1-2, ready in cycle 3.
    doReset();
    ramRdata = 16'hA123;
    applyStimulus(1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    checkOutput("t1_c0_cs",  ram_cs,   0);
    checkOutput("t1_c0_rdy", if_ready, 0);
    for (int c = 1; c <= 4; c++) begin
      nextCycle();
      #1;
      checkOutput($sformatf("t1_c%0d_cs", c),  ram_cs,   (c == 1 || c == 2));
      checkOutput($sformatf("t1_c%0d_rdy", c), if_ready, (c == 3));
      if (c <= 2) begin
        checkOutput($sformatf("t1_c%0d_addr", c), ram_addr, 16'h0004);
        checkOutput($sformatf("t1_c%0d_we", c),   ram_we,   0);
      end
      if (c == 3) begin
        checkOutput("t1_if_rdata", if_rdata, 16'hA123);
        if_req = 1'b0;
      end
    end

    // Simultaneous requests after reset: MEM first, then IF.
    doReset();
    ramRdata = 16'hBEEF;
    applyStimulus(1'b1, 16'h0100, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0);
    ifPulses = 0; memPulses = 0; ifAt = -1; memAt = -1;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) nextCycle();
      if (c == 4) ramRdata = 16'h1234;
      #1;
      if (c == 1) checkOutput("t2_first_addr",  ram_addr, 16'h0020);
      if (c == 5) checkOutput("t2_second_addr", ram_addr, 16'h0100);
      if (mem_ready) begin
        memPulses++; memAt = c;
        checkOutput("t2_mem_rdata", mem_rdata, 16'hBEEF);
        mem_req = 1'b0;
      end
      if (if_ready) begin
        ifPulses++; ifAt = c;
        checkOutput("t2_if_rdata", if_rdata, 16'h1234);
        if_req = 1'b0;
      end
    end
    checkOutput("t2_mem_pulses", memPulses, 1);
    checkOutput("t2_if_pulses",  ifPulses,  1);
    checkOutput("t2_mem_at",     memAt,     3);
    checkOutput("t2_if_at",      ifAt,      7);

    // Byte store: RAM controls held, load data untouched.
    nextCycle();
    ramRdata = 16'h5555;
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h0010, 16'h00FF);
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) nextCycle();
      #1;
      checkOutput($sformatf("t3_c%0d_rdy", c), mem_ready, (c == 3));
      if (c == 1 || c == 2) begin
        checkOutput($sformatf("t3_c%0d_cs", c),    ram_cs,    1);
        checkOutput($sformatf("t3_c%0d_we", c),    ram_we,    1);
        checkOutput($sformatf("t3_c%0d_byte", c),  ram_byte,  1);
        checkOutput($sformatf("t3_c%0d_addr", c),  ram_addr,  16'h0010);
        checkOutput($sformatf("t3_c%0d_wdata", c), ram_wdata, 16'h00FF);
      end
      if (c == 3) begin
        checkOutput("t3_mem_rdata", mem_rdata, 16'hBEEF);
        mem_req = 1'b0;
      end
    end

    // Cancel during ACCESS kills the pulse; the next fetch is served normally.
    nextCycle();
    ramRdata = 16'h7777;
    applyStimulus(1'b1, 16'h0008, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int c = 1; c <= 8; c++) begin
      nextCycle();
      if (c == 1) if_cancel = 1'b1;
      if (c == 2) if_cancel = 1'b0;
      if (c == 4) begin
        if_req   = 1'b1;
        if_addr  = 16'h000C;
        ramRdata = 16'h8888;
      end
      #1;
      checkOutput($sformatf("t4_c%0d_rdy", c), if_ready, (c == 7));
      if (c == 3) begin
        checkOutput("t4_killed_rdata", if_rdata, 16'h7777);
        if_req = 1'b0;
      end
      if (c == 7) begin
        checkOutput("t4_next_rdata", if_rdata, 16'h8888);
        if_req = 1'b0;
      end
    end

    // A cancel during RESP masks the ready combinationally.
    nextCycle();
    applyStimulus(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) nextCycle();
    if_cancel = 1'b1;
    #1;
    checkOutput("t4b_masked_rdy", if_ready, 0);
    if_cancel = 1'b0;
    #1;
    checkOutput("t4b_unmasked_rdy", if_ready, 1);
    if_req = 1'b0;

    // Reset mid-access, then regrant the pending MEM request ahead of IF.
    nextCycle();
    ramRdata = 16'h4321;
    applyStimulus(1'b1, 16'h0100, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0);
    nextCycle();
    #1;
    checkOutput("t5_pre_cs", ram_cs, 1);
    reset = 1'b0;
    #1;
    checkOutput("t5_rst_cs",      ram_cs,    0);
    checkOutput("t5_rst_memrdy",  mem_ready, 0);
    checkOutput("t5_rst_ifrdy",   if_ready,  0);
    nextCycle();
    reset = 1'b1;
    ifSeen = 1'b0;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) nextCycle();
      #1;
      checkOutput($sformatf("t5_c%0d_memrdy", c), mem_ready, (c == 3));
      if (c == 1) checkOutput("t5_regrant_addr", ram_addr, 16'h0030);
      if (c == 3) begin
        checkOutput("t5_mem_rdata", mem_rdata, 16'h4321);
        mem_req = 1'b0;
      end
      if (if_ready && !ifSeen) begin
        ifSeen = 1'b1;
        if_req = 1'b0;
      end
    end
    checkOutput("t5_if_served", ifSeen, 1);

`ifdef ARB_PERF_CNT_EN
    doReset();
    #1;
    checkOutput("t6_rst_ifcnt", if_wait_cnt, 0);
    applyStimulus(1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int c = 1; c <= 4; c++) begin
      nextCycle();
      #1;
      if (c == 3) if_req = 1'b0;
    end
    checkOutput("t6_if_wait_cnt",  if_wait_cnt,  3);
    checkOutput("t6_mem_wait_cnt", mem_wait_cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
